// File: rtl/mul54_arbiter_if.sv
// Handshake bundle between two operand sources, the shared
// multiplier sequencer and the result consumer.
interface mul54_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [4:0]       req0_a;
  logic [3:0]       req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [4:0]       req1_a;
  logic [3:0]       req1_b;
  logic             req1_ready;
  logic             rsp_valid;
  logic [8:0]       rsp_p;
  logic             rsp_id;
  logic             rsp_ready;
  logic             busy;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_p, rsp_id,
    input  busy, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_p, rsp_id,
    output busy, cnt0, cnt1
  );
endinterface

// File: rtl/mul54_arbiter.sv
// Round-robin sequencer sharing one signed 5x4
// Baugh-Wooley multiplier between two requesters.
module multiplier5x4 (
  input  logic [4:0] a,
  input  logic [3:0] b,
  output logic [8:0] p
);
  logic pp;

  // Sign rows are inverted; 0x118 folds in the correction terms.
  always_comb begin
    p  = 9'h118;
    pp = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 5; i++) begin
        pp = a[i] & b[j];
        if ((i == 4) != (j == 3)) pp = ~pp;
        p = p + (9'(pp) << (i + j));
      end
    end
  end
endmodule

module mul54_arbiter #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  mul54_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q;
  logic [4:0]       a_q;
  logic [3:0]       b_q;
  logic             id_q;
  logic [8:0]       rsp_p_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  logic       any_v;
  logic       gnt_id;
  logic       gnt;
  logic       ready0, ready1;
  logic       rsp_valid, busy;
  logic [8:0] prod;

  always_comb begin
    any_v  = bus.req0_valid | bus.req1_valid;
    gnt_id = (bus.req0_valid & bus.req1_valid)
           ? rr_q : bus.req1_valid;
    gnt    = (state_q == IDLE) & any_v & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready0    = 1'b0;
    ready1    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (1'b1)
      (state_q == IDLE): begin
        busy   = 1'b0;
        ready0 = gnt & ~gnt_id;
        ready1 = gnt & gnt_id;
      end
      (state_q == RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  multiplier5x4 u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rsp_p_q  <= '0;
      rsp_id_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      if (gnt) begin
        a_q  <= gnt_id ? bus.req1_a : bus.req0_a;
        b_q  <= gnt_id ? bus.req1_b : bus.req0_b;
        id_q <= gnt_id;
        rr_q <= ~gnt_id;
      end
      if (state_q == MUL) begin
        rsp_p_q  <= prod;
        rsp_id_q <= id_q;
      end
      if (ready0 && cnt0_q != '1)
        cnt0_q <= cnt0_q + CNT_W'(1);
      if (ready1 && cnt1_q != '1)
        cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_p      = rsp_p_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = busy;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;
endmodule
